// File: rtl/mdu_hilo_ctrl.sv
// HI/LO register pair and multiply/divide sequencer for the EXE stage.
// Products are computed in place; quotients come from an external AXI-stream divider.
module mdu_hilo_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic        op_valid,
   input  logic [2:0]  op_code,
   input  logic [31:0] op_src1,
   input  logic [31:0] op_src2,
   input  logic        op_ack,
   input  logic        flush,
   output logic        op_ready,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_signed,
   output logic        div_tvalid,
   input  logic        div_tready,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   input  logic        div_dout_tvalid,
   input  logic [63:0] div_dout
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] DIV_ISSUE = 3'd1;
   localparam logic [2:0] DIV_WAIT  = 3'd2;
   localparam logic [2:0] DONE      = 3'd3;
   localparam logic [2:0] DRAIN     = 3'd4;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic [2:0]  state;
   logic [31:0] pend_hi;
   logic [31:0] pend_lo;
   logic        en_hi;
   logic        en_lo;
   logic        issue_flushed;
   logic [63:0] prod_signed;
   logic [63:0] prod_unsigned;

   assign prod_signed   = $signed({{32{op_src1[31]}}, op_src1}) * $signed({{32{op_src2[31]}}, op_src2});
   assign prod_unsigned = {32'd0, op_src1} * {32'd0, op_src2};

   assign op_ready   = (state == DONE);
   assign busy       = (state != IDLE);
   assign div_tvalid = (state == DIV_ISSUE);

   // A flush during DIV_ISSUE cannot retract tvalid, so it is remembered in
   // issue_flushed and turned into a DRAIN once the handshake completes.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         hi            <= 32'd0;
         lo            <= 32'd0;
         pend_hi       <= 32'd0;
         pend_lo       <= 32'd0;
         en_hi         <= 1'b0;
         en_lo         <= 1'b0;
         issue_flushed <= 1'b0;
         div_signed    <= 1'b0;
         div_dividend  <= 32'd0;
         div_divisor   <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (op_valid && !flush) begin
                  case (op_code)
                     OP_MULT: begin
                        pend_hi <= prod_signed[63:32];
                        pend_lo <= prod_signed[31:0];
                        en_hi   <= 1'b1;
                        en_lo   <= 1'b1;
                        state   <= DONE;
                     end
                     OP_MULTU: begin
                        pend_hi <= prod_unsigned[63:32];
                        pend_lo <= prod_unsigned[31:0];
                        en_hi   <= 1'b1;
                        en_lo   <= 1'b1;
                        state   <= DONE;
                     end
                     OP_DIV, OP_DIVU: begin
                        div_dividend  <= op_src1;
                        div_divisor   <= op_src2;
                        div_signed    <= (op_code == OP_DIV);
                        issue_flushed <= 1'b0;
                        state         <= DIV_ISSUE;
                     end
                     OP_MTHI: begin
                        pend_hi <= op_src1;
                        en_hi   <= 1'b1;
                        en_lo   <= 1'b0;
                        state   <= DONE;
                     end
                     OP_MTLO: begin
                        pend_lo <= op_src1;
                        en_hi   <= 1'b0;
                        en_lo   <= 1'b1;
                        state   <= DONE;
                     end
                     default: begin
                        state <= IDLE;
                     end
                  endcase
               end
            end
            DIV_ISSUE: begin
               if (div_tready) begin
                  state <= (issue_flushed || flush) ? DRAIN : DIV_WAIT;
               end else if (flush) begin
                  issue_flushed <= 1'b1;
               end
            end
            DIV_WAIT: begin
               if (div_dout_tvalid) begin
                  if (flush) begin
                     state <= IDLE;
                  end else begin
                     pend_lo <= div_dout[63:32];
                     pend_hi <= div_dout[31:0];
                     en_hi   <= 1'b1;
                     en_lo   <= 1'b1;
                     state   <= DONE;
                  end
               end else if (flush) begin
                  state <= DRAIN;
               end
            end
            DONE: begin
               if (flush) begin
                  state <= IDLE;
               end else if (op_ack) begin
                  if (en_hi) hi <= pend_hi;
                  if (en_lo) lo <= pend_lo;
                  state <= IDLE;
               end
            end
            DRAIN: begin
               if (div_dout_tvalid) state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Bench for mdu_hilo_ctrl: a behavioural divider on the AXI side, a vector table,
// hand-written flush/reset sequences and a randomized run against an arithmetic model.
module tb_mdu_hilo_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [31:0] op_src1;
   logic [31:0] op_src2;
   logic        op_ack;
   logic        flush;
   logic        op_ready;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_signed;
   logic        div_tvalid;
   logic        div_tready = 1'b0;
   logic [31:0] div_dividend;
   logic [31:0] div_divisor;
   logic        div_dout_tvalid = 1'b0;
   logic [63:0] div_dout = 64'd0;

   int vec_count   = 0;
   int miscompares = 0;
   int ready_delay = 0;
   int div_latency = 1;
   int wait_cnt    = 0;
   int lat_cnt     = 0;
   bit pending     = 1'b0;
   logic [63:0] div_result;
   logic [31:0] ref_hi;
   logic [31:0] ref_lo;

   typedef struct {
      logic [2:0]  code;
      logic [31:0] src1;
      logic [31:0] src2;
      int          ack_delay;
      int          rdy_delay;
      int          latency;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[12];

   mdu_hilo_ctrl dut (
      .clk(clk),
      .resetn(resetn),
      .op_valid(op_valid),
      .op_code(op_code),
      .op_src1(op_src1),
      .op_src2(op_src2),
      .op_ack(op_ack),
      .flush(flush),
      .op_ready(op_ready),
      .busy(busy),
      .hi(hi),
      .lo(lo),
      .div_signed(div_signed),
      .div_tvalid(div_tvalid),
      .div_tready(div_tready),
      .div_dividend(div_dividend),
      .div_divisor(div_divisor),
      .div_dout_tvalid(div_dout_tvalid),
      .div_dout(div_dout)
   );

   always #5 clk = ~clk;

   // Divider result as {quotient, remainder}; divide by zero returns all-ones / dividend
   function automatic logic [63:0] divResult(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      int          sa;
      int          sb;
      int unsigned ua;
      int unsigned ub;
      if (b == 32'd0) return {32'hFFFFFFFF, a};
      if (sgn) begin
         sa = a;
         sb = b;
         return {32'(sa / sb), 32'(sa % sb)};
      end
      ua = a;
      ub = b;
      return {32'(ua / ub), 32'(ua % ub)};
   endfunction

   // Architectural effect of one committed instruction, as {hi, lo}
   function automatic logic [63:0] refOp(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] cur_hi, input logic [31:0] cur_lo);
      longint      sp;
      logic [63:0] qr;
      case (code)
         3'd1: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return 64'(sp);
         end
         3'd2: return {32'd0, a} * {32'd0, b};
         3'd3, 3'd4: begin
            qr = divResult(code == 3'd3, a, b);
            return {qr[31:0], qr[63:32]};
         end
         3'd5: return {a, cur_lo};
         3'd6: return {cur_hi, a};
         default: return {cur_hi, cur_lo};
      endcase
   endfunction

   // Divider model: tready after ready_delay cycles of tvalid, one-cycle result pulse div_latency cycles later
   always @(negedge clk) begin
      div_dout_tvalid = 1'b0;
      if (!resetn) begin
         div_tready = 1'b0;
         pending    = 1'b0;
         wait_cnt   = 0;
         lat_cnt    = 0;
      end else begin
         if (pending) begin
            lat_cnt = lat_cnt - 1;
            if (lat_cnt == 0) begin
               div_dout_tvalid = 1'b1;
               div_dout        = div_result;
               pending         = 1'b0;
            end
         end
         div_tready = 1'b0;
         if (div_tvalid) begin
            if (wait_cnt >= ready_delay) begin
               div_tready = 1'b1;
               div_result = divResult(div_signed, div_dividend, div_divisor);
               pending    = 1'b1;
               lat_cnt    = div_latency;
               wait_cnt   = 0;
            end else begin
               wait_cnt = wait_cnt + 1;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vec_count = vec_count + 1;
      if (actual !== expected) begin
         miscompares = miscompares + 1;
         $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
      end
   endtask

   task automatic waitReady(input string tag, input int max_cycles, output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles = cycles + 1;
      end while (!op_ready && cycles < max_cycles);
      if (!op_ready) checkOutput({tag, " ready timeout"}, 64'(op_ready), 64'd1);
   endtask

   task automatic applyStimulus(input string tag, input logic [2:0] code, input logic [31:0] a,
                                input logic [31:0] b, input int ack_delay,
                                input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int          cycles;
      int          tv_cycles;
      bit          is_div;
      logic [31:0] hi_before;
      logic [31:0] lo_before;
      is_div    = (code == 3'd3) || (code == 3'd4);
      hi_before = hi;
      lo_before = lo;
      @(negedge clk);
      op_valid  = 1'b1;
      op_code   = code;
      op_src1   = a;
      op_src2   = b;
      flush     = 1'b0;
      op_ack    = 1'b0;
      cycles    = 0;
      tv_cycles = 0;
      do begin
         @(negedge clk);
         cycles = cycles + 1;
         if (div_tvalid) begin
            tv_cycles = tv_cycles + 1;
            if (tv_cycles == 1) begin
               checkOutput({tag, " div_signed"}, 64'(div_signed), 64'(code == 3'd3));
               checkOutput({tag, " operands"}, {div_dividend, div_divisor}, {a, b});
            end
         end
      end while (!op_ready && cycles < 300);
      checkOutput({tag, " ready latency"}, 64'(cycles), is_div ? 64'(ready_delay + div_latency + 2) : 64'd1);
      if (is_div) checkOutput({tag, " tvalid cycles"}, 64'(tv_cycles), 64'(ready_delay + 1));
      for (int i = 0; i < ack_delay; i++) begin
         @(negedge clk);
         checkOutput({tag, " ready held"}, 64'(op_ready), 64'd1);
         checkOutput({tag, " hilo before ack"}, {hi, lo}, {hi_before, lo_before});
      end
      op_ack = 1'b1;
      @(negedge clk);
      op_ack   = 1'b0;
      op_valid = 1'b0;
      checkOutput({tag, " hi"}, 64'(hi), 64'(exp_hi));
      checkOutput({tag, " lo"}, 64'(lo), 64'(exp_lo));
      checkOutput({tag, " idle after ack"}, {62'd0, op_ready, busy}, 64'd0);
      ref_hi = exp_hi;
      ref_lo = exp_lo;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          cycles;
      int          tv_cycles;
      bit          saw_ready;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rc;
      logic [63:0] rexp;

      vecs[0]  = '{3'd1, 32'hFFFFFFFD, 32'd5,        0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        3, 0, 1, 32'h00000001, 32'hFFFFFFFE};
      vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        0, 2, 8, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{3'd4, 32'd100,      32'd7,        0, 0, 3, 32'h00000002, 32'h0000000E};
      vecs[4]  = '{3'd5, 32'h00001234, 32'hDEAD,     0, 0, 1, 32'h00001234, 32'h0000000E};
      vecs[5]  = '{3'd6, 32'h0000ABCD, 32'hDEAD,     1, 0, 1, 32'h00001234, 32'h0000ABCD};
      vecs[6]  = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 1, 32'h3FFFFFFF, 32'h00000001};
      vecs[7]  = '{3'd1, 32'h80000000, 32'h80000000, 0, 0, 1, 32'h40000000, 32'h00000000};
      vecs[8]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 32'hFFFFFFFE, 32'h00000001};
      vecs[9]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 0, 1, 5, 32'h00000001, 32'hFFFFFFFD};
      vecs[10] = '{3'd4, 32'd5,        32'd0,        0, 0, 2, 32'h00000005, 32'hFFFFFFFF};
      vecs[11] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 32'h00000000, 32'h00000001};

      resetn   = 1'b0;
      op_valid = 1'b0;
      op_code  = 3'd0;
      op_src1  = 32'd0;
      op_src2  = 32'd0;
      op_ack   = 1'b0;
      flush    = 1'b0;
      ref_hi   = 32'd0;
      ref_lo   = 32'd0;
      repeat (2) @(negedge clk);
      checkOutput("reset hilo", {hi, lo}, 64'd0);
      checkOutput("reset flags", {60'd0, op_ready, busy, div_tvalid, div_signed}, 64'd0);
      checkOutput("reset operands", {div_dividend, div_divisor}, 64'd0);
      resetn = 1'b1;

      for (int i = 0; i < 12; i++) begin
         ready_delay = vecs[i].rdy_delay;
         div_latency = vecs[i].latency;
         applyStimulus($sformatf("vec%0d", i), vecs[i].code, vecs[i].src1, vecs[i].src2,
                       vecs[i].ack_delay, vecs[i].exp_hi, vecs[i].exp_lo);
      end

      // flush and ack together in DONE: flush wins
      @(negedge clk);
      op_valid = 1'b1;
      op_code  = 3'd1;
      op_src1  = 32'd3;
      op_src2  = 32'd4;
      waitReady("flushack", 20, cycles);
      flush  = 1'b1;
      op_ack = 1'b1;
      @(negedge clk);
      flush    = 1'b0;
      op_ack   = 1'b0;
      op_valid = 1'b0;
      checkOutput("flushack hilo", {hi, lo}, {ref_hi, ref_lo});
      checkOutput("flushack idle", {62'd0, op_ready, busy}, 64'd0);

      // divu flushed in DIV_WAIT, mthi presented right behind it
      ready_delay = 0;
      div_latency = 8;
      @(negedge clk);
      op_valid = 1'b1;
      op_code  = 3'd4;
      op_src1  = 32'd100;
      op_src2  = 32'd7;
      @(negedge clk);
      checkOutput("drain tvalid", 64'(div_tvalid), 64'd1);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush   = 1'b0;
      op_code = 3'd5;
      op_src1 = 32'h00001234;
      op_src2 = 32'd0;
      checkOutput("drain state", {62'd0, op_ready, busy}, 64'd1);
      waitReady("drain", 50, cycles);
      checkOutput("drain ready cycles", 64'(cycles), 64'(div_latency));
      op_ack = 1'b1;
      @(negedge clk);
      op_ack   = 1'b0;
      op_valid = 1'b0;
      checkOutput("drain mthi", {hi, lo}, {32'h00001234, ref_lo});
      ref_hi = 32'h00001234;

      // flush in DIV_ISSUE while tready is low: tvalid must hold until the handshake
      ready_delay = 3;
      div_latency = 4;
      @(negedge clk);
      op_valid = 1'b1;
      op_code  = 3'd3;
      op_src1  = 32'd50;
      op_src2  = 32'd3;
      @(negedge clk);
      flush     = 1'b1;
      tv_cycles = 0;
      cycles    = 0;
      while (div_tvalid && cycles < 20) begin
         tv_cycles = tv_cycles + 1;
         @(negedge clk);
         cycles = cycles + 1;
      end
      flush    = 1'b0;
      op_valid = 1'b0;
      checkOutput("issueflush tvalid cycles", 64'(tv_cycles), 64'd4);
      checkOutput("issueflush drain", {62'd0, op_ready, busy}, 64'd1);
      saw_ready = 1'b0;
      cycles    = 0;
      while (busy && cycles < 30) begin
         @(negedge clk);
         if (op_ready) saw_ready = 1'b1;
         cycles = cycles + 1;
      end
      checkOutput("issueflush back to idle", 64'(busy), 64'd0);
      checkOutput("issueflush no ready", 64'(saw_ready), 64'd0);
      checkOutput("issueflush hilo", {hi, lo}, {ref_hi, ref_lo});

      // reset asserted mid-divide
      ready_delay = 0;
      div_latency = 10;
      @(negedge clk);
      op_valid = 1'b1;
      op_code  = 3'd3;
      op_src1  = 32'hFFFFFF00;
      op_src2  = 32'd16;
      repeat (2) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      op_valid = 1'b0;
      checkOutput("midreset hilo", {hi, lo}, 64'd0);
      checkOutput("midreset flags", {60'd0, op_ready, busy, div_tvalid, div_signed}, 64'd0);
      checkOutput("midreset operands", {div_dividend, div_divisor}, 64'd0);
      @(negedge clk);
      #2 resetn = 1'b1;
      ref_hi = 32'd0;
      ref_lo = 32'd0;
      div_latency = 1;
      applyStimulus("postreset", 3'd1, 32'd6, 32'd7, 0, 32'd0, 32'd42);

      // randomized ops against the arithmetic model
      for (int n = 0; n < 40; n++) begin
         rc = 3'($urandom_range(1, 6));
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            ra = 32'($urandom_range(0, 20));
            rb = 32'($urandom_range(0, 5));
         end
         if (rc == 3'd3 && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
         ready_delay = $urandom_range(0, 3);
         div_latency = $urandom_range(1, 10);
         rexp = refOp(rc, ra, rb, ref_hi, ref_lo);
         applyStimulus($sformatf("rand%0d op%0d", n, rc), rc, ra, rb, $urandom_range(0, 2),
                       rexp[63:32], rexp[31:0]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
      $finish;
   end

endmodule

// File: doc/mdu_hilo_ctrl.md
# mdu_hilo_ctrl

Sequencer for the multiply/divide unit and the HI/LO register pair in the EXE stage. It accepts mult/multu/div/divu/mthi/mtlo operations from EXE and computes products internally. It drives the signed or unsigned divider IP over its AXI-stream handshake and holds EXE via `op_ready` until the result is available. HI/LO commit only when EXE hands the instruction to MEM, so a flushed instruction never changes HI/LO.

## Interface
Parameters:
- none; data width fixed at 32.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `op_valid` in 1: EXE holds a valid MDU instruction.
- `op_code` in 3: 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo; 0 and 7 are illegal when `op_valid` is high.
- `op_src1` in 32: rs value (dividend / multiplicand / mthi-mtlo source).
- `op_src2` in 32: rt value (divisor / multiplier).
- `op_ack` in 1: EXE passes this instruction to MEM this cycle (es_ready_go && ms_allowin).
- `flush` in 1: cancel the in-flight instruction.
- `op_ready` out 1: result pending and ready to commit; EXE uses it as es_ready_go.
- `busy` out 1: state != IDLE.
- `hi`, `lo` out 32 each: architectural HI/LO, read by mfhi/mflo.
- `div_signed` out 1: 1 routes to the signed divider, 0 to the unsigned divider.
- `div_tvalid` out 1: drives both dividend and divisor tvalid.
- `div_tready` in 1: AND of the selected divider's dividend and divisor tready.
- `div_dividend`, `div_divisor` out 32 each: latched operands.
- `div_dout_tvalid` in 1: selected divider's result valid.
- `div_dout` in 64: quotient [63:32], remainder [31:0].

## Operation
- States: IDLE, DIV_ISSUE, DIV_WAIT, DONE, DRAIN.
- IDLE, `op_valid` && !`flush`:
  - mult/multu: compute the 64-bit signed/unsigned product of src1×src2 into pend_hi/pend_lo; enable both; go to DONE.
  - mthi: pend_hi=src1, HI-only enable; go to DONE. mtlo: likewise for LO.
  - div/divu: latch operands and `div_signed`; go to DIV_ISSUE.
- DIV_ISSUE: `div_tvalid`=1. On `div_tready`, go to DIV_WAIT; `div_tvalid` drops the next cycle.
- DIV_WAIT: on `div_dout_tvalid`, capture pend_lo=quotient and pend_hi=remainder, enable both, go to DONE.
- DONE: `op_ready`=1.
  - `op_ack`: write the enabled HI/LO from pend, go to IDLE.
  - `flush`: discard pend, go to IDLE.
  - `op_ack` and `flush` together: flush wins, no write.
- Flush:
  - IDLE with `op_valid`: operation is not accepted.
  - DIV_ISSUE: `div_tvalid` stays high until the handshake completes (AXI rule), then go to DRAIN.
  - DIV_WAIT: go to DRAIN.
  - DIV_WAIT with `div_dout_tvalid` in the same cycle: go to IDLE, result discarded.
- DRAIN: `op_ready`=0; wait for `div_dout_tvalid`, discard it, go to IDLE. New ops stall until then.
- Divide by zero: the divider output is committed as returned; no trap.
- Illegal inputs (assertion targets, behaviour undefined):
  - `op_ack` outside DONE.
  - `op_valid` low in DIV_ISSUE/DIV_WAIT/DONE without `flush`.
  - `op_code` 0/7 with `op_valid`.

## Timing
- Reset (async on `resetn` low):
  - state IDLE.
  - `hi`=`lo`=0.
  - `op_ready`=0, `busy`=0, `div_tvalid`=0, `div_signed`=0.
  - `div_dividend`=`div_divisor`=0.
- All outputs are registered or decoded from state; no combinational path from `op_*` to `op_ready`.
- Mult/mthi/mtlo latency: accepted at edge N, `op_ready` high in cycle N+1; commit at the `op_ack` edge.
- Div latency: `div_tvalid` high from cycle N+1; result captured at the edge where `div_dout_tvalid` is seen; `op_ready` high the cycle after.
- HI/LO update at the `op_ack` edge. An mfhi/mflo entering EXE on that same edge reads the new value, so there is no hazard.
- `busy` is high from the cycle after acceptance until the return to IDLE, including DRAIN.

## Test plan
- mult src1=0xFFFFFFFD, src2=5 → `op_ready` 1 cycle later; after `op_ack`, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu 0xFFFFFFFF×2 with `op_ack` held low 3 cycles → `op_ready` stays high and HI/LO are unchanged until ack; then HI=0x1, LO=0xFFFFFFFE.
- div −7/2 with the divider model at 8-cycle latency and tready low 2 cycles → `div_tvalid` held until tready and `div_signed`=1; after ack, LO=0xFFFFFFFD, HI=0xFFFFFFFF. A following mflo reads 0xFFFFFFFD.
- divu 100/7 flushed in DIV_WAIT, new mthi 0x1234 presented immediately → DRAIN until dout, mthi then accepted; HI=0x1234, LO unchanged from the prior value.
- mult in DONE with `flush` and `op_ack` together → HI/LO unchanged, next state IDLE.
- `resetn` pulled low mid-divide → all outputs return to reset values immediately; first op after release behaves normally.
